// File: rtl/rand_fill_ctrl.sv
// Fill sequencer: samples the LFSR every STRIDE cycles, filters each value
// and streams accepted values to consecutive array addresses.
module rand_fill_ctrl #(
  parameter int unsigned N         = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned STRIDE    = 1,
  parameter int unsigned MAX_VAL   = 15,
  parameter int unsigned REJ_LIMIT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              uniq,
  input  logic [3:0]        rnd_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned VAL_W = 4;
  localparam int unsigned REJ_W = 8;

  localparam logic [VAL_W-1:0]  STRIDE_RELOAD = VAL_W'(STRIDE - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX      = ADDR_W'(N - 1);
  localparam logic [REJ_W-1:0]  REJ_MAX       = REJ_W'(REJ_LIMIT);
  localparam logic [VAL_W:0]    MAX_VAL_X     = (VAL_W + 1)'(MAX_VAL);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [15:0]         seen_q, seen_d;
  logic [REJ_W-1:0]    rej_q, rej_d;
  logic [VAL_W-1:0]    stride_q, stride_d;
  logic                uniq_q, uniq_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [VAL_W-1:0]    wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                accept_c;

  // Sample filter: non-zero, within range, and unseen when uniqueness is on
  always_comb begin
    accept_c = (rnd_in != '0) && ({1'b0, rnd_in} <= MAX_VAL_X) &&
               !(uniq_q && seen_q[rnd_in]);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seen_d    = seen_q;
    rej_d     = rej_q;
    stride_d  = stride_q;
    uniq_d    = uniq_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = RUN;
          idx_d    = '0;
          seen_d   = '0;
          rej_d    = '0;
          stride_d = STRIDE_RELOAD;
          uniq_d   = uniq;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (stride_q != '0) begin
          stride_d = stride_q - VAL_W'(1);
        end else begin
          stride_d = STRIDE_RELOAD;
          if (accept_c) begin
            wr_en_d        = 1'b1;
            wr_addr_d      = idx_q;
            wr_data_d      = rnd_in;
            seen_d[rnd_in] = 1'b1;
            rej_d          = '0;
            if (idx_q == LAST_IDX) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              idx_d = idx_q + ADDR_W'(1);
            end
          end else begin
            rej_d = rej_q + REJ_W'(1);
            // Watchdog: too many consecutive rejects means the source is stuck
            if (rej_q + REJ_W'(1) == REJ_MAX) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      seen_q    <= '0;
      rej_q     <= '0;
      stride_q  <= '0;
      uniq_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seen_q    <= seen_d;
      rej_q     <= rej_d;
      stride_q  <= stride_d;
      uniq_q    <= uniq_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_rand_fill_ctrl.sv
// Bench for rand_fill_ctrl: two differently parameterised instances share the
// stimulus and are checked every cycle against a transaction-level model.
module tb_rand_fill_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       uniq;
  logic [3:0] rnd_in;

  logic       a_wr_en, a_busy, a_done, a_err;
  logic [1:0] a_wr_addr;
  logic [3:0] a_wr_data;
  logic       b_wr_en, b_busy, b_done, b_err;
  logic [1:0] b_wr_addr;
  logic [3:0] b_wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rand_fill_ctrl #(.N(4), .ADDR_W(2), .STRIDE(1), .MAX_VAL(8), .REJ_LIMIT(32)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .uniq(uniq), .rnd_in(rnd_in),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  rand_fill_ctrl #(.N(3), .ADDR_W(2), .STRIDE(3), .MAX_VAL(15), .REJ_LIMIT(5)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .uniq(uniq), .rnd_in(rnd_in),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  function automatic int p_n(input int i);      return (i == 0) ? 4  : 3; endfunction
  function automatic int p_stride(input int i); return (i == 0) ? 1  : 3; endfunction
  function automatic int p_max(input int i);    return (i == 0) ? 8  : 15; endfunction
  function automatic int p_rej(input int i);    return (i == 0) ? 32 : 5; endfunction

  // Model state: a fill in flight, cycles since start, next slot, reject run
  bit        m_act  [2];
  int        m_t    [2];
  int        m_idx  [2];
  int        m_rej  [2];
  bit [15:0] m_seen [2];
  bit        m_uq   [2];
  logic        e_we   [2];
  logic [31:0] e_addr [2];
  logic [31:0] e_data [2];
  logic        e_done [2];
  logic        e_err  [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_t[i] = 0; m_idx[i] = 0; m_rej[i] = 0; m_seen[i] = '0; m_uq[i] = 0;
      e_we[i] = 0; e_addr[i] = 0; e_data[i] = 0; e_done[i] = 0; e_err[i] = 0;
    end
  endtask

  task automatic model_edge(input int i);
    bit ok;
    e_we[i] = 0; e_done[i] = 0; e_err[i] = 0;
    if (!m_act[i]) begin
      if (start && !abort) begin
        m_act[i] = 1; m_t[i] = 0; m_idx[i] = 0; m_rej[i] = 0; m_seen[i] = '0; m_uq[i] = uniq;
      end
    end else if (abort) begin
      m_act[i] = 0;
    end else begin
      m_t[i]++;
      if (m_t[i] % p_stride(i) == 0) begin
        ok = (int'(rnd_in) != 0) && (int'(rnd_in) <= p_max(i)) &&
             !(m_uq[i] && m_seen[i][rnd_in]);
        if (ok) begin
          e_we[i] = 1; e_addr[i] = 32'(m_idx[i]); e_data[i] = 32'(rnd_in);
          m_seen[i][rnd_in] = 1'b1;
          m_rej[i] = 0;
          if (m_idx[i] == p_n(i) - 1) begin
            e_done[i] = 1; m_act[i] = 0;
          end else begin
            m_idx[i]++;
          end
        end else begin
          m_rej[i]++;
          if (m_rej[i] == p_rej(i)) begin
            e_err[i] = 1; m_act[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_wr_en",   32'(a_wr_en),   32'(e_we[0]));
    chk("a_wr_addr", 32'(a_wr_addr), e_addr[0]);
    chk("a_wr_data", 32'(a_wr_data), e_data[0]);
    chk("a_busy",    32'(a_busy),    32'(m_act[0]));
    chk("a_done",    32'(a_done),    32'(e_done[0]));
    chk("a_err",     32'(a_err),     32'(e_err[0]));
    chk("b_wr_en",   32'(b_wr_en),   32'(e_we[1]));
    chk("b_wr_addr", 32'(b_wr_addr), e_addr[1]);
    chk("b_wr_data", 32'(b_wr_data), e_data[1]);
    chk("b_busy",    32'(b_busy),    32'(m_act[1]));
    chk("b_done",    32'(b_done),    32'(e_done[1]));
    chk("b_err",     32'(b_err),     32'(e_err[1]));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check after it
  task automatic cycle(input bit st, input bit ab, input bit uq, input logic [3:0] rn);
    start = st; abort = ab; uniq = uq; rnd_in = rn;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all();
  endtask

  task automatic feed(input bit uq, input logic [3:0] vals[$]);
    foreach (vals[k]) cycle(1'b0, 1'b0, uq, vals[k]);
  endtask

  logic [3:0] lfsr_seq[$];
  int         a_busy_cycles;

  initial begin
    rst = 1'b1; start = 0; abort = 0; uniq = 0; rnd_in = '0;
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all();

    // Basic fill, then best-case busy length on the stride-1 instance
    cycle(1, 0, 0, 4'd0);
    feed(0, '{4'd9, 4'd3, 4'd6, 4'd13});
    feed(0, '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6});
    cycle(0, 1, 0, 4'd0);

    cycle(1, 0, 0, 4'd0);
    a_busy_cycles = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(0, 0, 0, 4'(k + 1));
      if (a_busy) a_busy_cycles++;
    end
    chk("a_busy_len", 32'(a_busy_cycles), 32'd3);
    cycle(0, 1, 0, 4'd0);

    // LFSR order with range filter
    lfsr_seq = '{4'd9, 4'd3, 4'd6, 4'd13, 4'd10, 4'd5, 4'd11, 4'd7};
    cycle(1, 0, 0, 4'd0);
    feed(0, lfsr_seq);
    feed(0, lfsr_seq);
    cycle(0, 1, 0, 4'd0);

    // Uniqueness: repeats and zeros rejected
    cycle(1, 0, 1, 4'd0);
    feed(0, '{4'd5, 4'd5, 4'd0, 4'd2, 4'd2, 4'd5, 4'd7, 4'd7, 4'd7, 4'd1, 4'd8, 4'd4});
    cycle(0, 1, 0, 4'd0);

    // Constant value, no uniqueness
    cycle(1, 0, 0, 4'd0);
    repeat (12) cycle(0, 0, 0, 4'd4);
    cycle(0, 1, 0, 4'd0);

    // Abort on the second sample, then restart at address 0
    cycle(1, 0, 0, 4'd0);
    cycle(0, 0, 0, 4'd3);
    cycle(0, 1, 0, 4'd5);
    cycle(0, 0, 0, 4'd6);
    cycle(1, 1, 0, 4'd0);
    cycle(1, 0, 0, 4'd0);
    feed(0, '{4'd2, 4'd7, 4'd1, 4'd8, 4'd6, 4'd4});
    cycle(0, 1, 0, 4'd0);

    // Stuck-at-zero source trips the watchdog on both instances
    cycle(1, 0, 0, 4'd0);
    repeat (36) cycle(0, 0, 0, 4'd0);
    cycle(1, 0, 0, 4'd3);
    cycle(0, 0, 0, 4'd3);

    // Asynchronous reset mid-fill
    cycle(1, 0, 0, 4'd0);
    cycle(0, 0, 0, 4'd6);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 rst = 1'b0;
    cycle(0, 0, 0, 4'd6);
    cycle(1, 0, 0, 4'd0);
    feed(0, '{4'd1, 4'd2, 4'd3, 4'd4});

    // Randomised traffic
    for (int k = 0; k < 500; k++) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
